// File: rtl/shared_mem_arbiter_if.sv
// Core/memory bus of the shared data-memory arbiter. The arbiter uses the slave view.
// SHARED_MEM_LOCK_EN adds the per-core Lock input.
interface shared_mem_arbiter_if #(
    parameter int NUM_CORES = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
);
    logic [NUM_CORES-1:0]        Req;
    logic [NUM_CORES-1:0]        We;
    logic [NUM_CORES*ADDR_W-1:0] Addr;
    logic [NUM_CORES*DATA_W-1:0] WData;
`ifdef SHARED_MEM_LOCK_EN
    logic [NUM_CORES-1:0]        Lock;
`endif
    logic [NUM_CORES-1:0]        Ack;
    logic [DATA_W-1:0]           RData;
    logic                        MemEn;
    logic                        MemWe;
    logic [ADDR_W-1:0]           MemAddr;
    logic [DATA_W-1:0]           MemWData;
    logic [DATA_W-1:0]           MemRData;
    logic                        Busy;

    modport slave (
        input  Req, We, Addr, WData, MemRData,
`ifdef SHARED_MEM_LOCK_EN
        input  Lock,
`endif
        output Ack, RData, MemEn, MemWe, MemAddr, MemWData, Busy
    );

    modport master (
        output Req, We, Addr, WData, MemRData,
`ifdef SHARED_MEM_LOCK_EN
        output Lock,
`endif
        input  Ack, RData, MemEn, MemWe, MemAddr, MemWData, Busy
    );
endinterface

// File: rtl/shared_mem_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous memory among NUM_CORES cores.
// Define SHARED_MEM_LOCK_EN to let a core hold the memory across back-to-back accesses.
module shared_mem_arbiter #(
    parameter int NUM_CORES = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
) (
    input  logic                  Clk,
    input  logic                  Reset,
    shared_mem_arbiter_if.slave   bus
);
    localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, ACK} state_t;

    state_t               state_reg;
    logic [IDX_W-1:0]     ptr_reg;
    logic [IDX_W-1:0]     gnt_reg;
    logic [NUM_CORES-1:0] ack_reg;
    logic                 store_reg;
    logic                 mem_en_reg;
    logic                 mem_we_reg;
    logic [ADDR_W-1:0]    mem_addr_reg;
    logic [DATA_W-1:0]    mem_wdata_reg;

    logic [ADDR_W-1:0]    addr_arr  [NUM_CORES];
    logic [DATA_W-1:0]    wdata_arr [NUM_CORES];

    generate
        for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_unpack
            assign addr_arr[gi]  = bus.Addr[gi*ADDR_W +: ADDR_W];
            assign wdata_arr[gi] = bus.WData[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // First set bit of mask at or after start, wrapping past NUM_CORES-1.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_CORES-1:0] mask,
                                                 input logic [IDX_W-1:0]     start);
        logic [IDX_W-1:0] win;
        logic [IDX_W-1:0] c;
        win = '0;
        for (int k = NUM_CORES - 1; k >= 0; k--) begin
            c = IDX_W'((int'(start) + k) % NUM_CORES);
            if (mask[c]) win = c;
        end
        return win;
    endfunction

    logic [NUM_CORES-1:0] gnt_oh;
    logic [NUM_CORES-1:0] cand;
    logic [IDX_W-1:0]     gnt_inc;
    logic [IDX_W-1:0]     start;
    logic [IDX_W-1:0]     win;
    logic                 locked;
    logic                 launch;
    logic                 issue_we;
    logic [ADDR_W-1:0]    issue_addr;
    logic [DATA_W-1:0]    issue_wdata;

    always_comb begin
        gnt_oh  = NUM_CORES'(1) << gnt_reg;
        gnt_inc = IDX_W'((int'(gnt_reg) + 1) % NUM_CORES);
        locked  = 1'b0;
`ifdef SHARED_MEM_LOCK_EN
        locked  = (state_reg == ACK) && bus.Lock[gnt_reg];
`endif
        // In ACK the just-served core is excluded, unless it holds the lock.
        if (state_reg == ACK) begin
            cand  = locked ? (bus.Req & gnt_oh) : (bus.Req & ~gnt_oh);
            start = locked ? gnt_reg : gnt_inc;
        end else begin
            cand  = bus.Req;
            start = ptr_reg;
        end
        win    = rr_pick(cand, start);
        launch = ((state_reg == IDLE) || (state_reg == ACK)) && (|cand);

        issue_we    = bus.We[0];
        issue_addr  = addr_arr[0];
        issue_wdata = wdata_arr[0];
        for (int i = 1; i < NUM_CORES; i++) begin
            if (win == IDX_W'(i)) begin
                issue_we    = bus.We[i];
                issue_addr  = addr_arr[i];
                issue_wdata = wdata_arr[i];
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_reg     <= IDLE;
            ptr_reg       <= '0;
            gnt_reg       <= '0;
            ack_reg       <= '0;
            store_reg     <= 1'b0;
            mem_en_reg    <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
        end else begin
            ack_reg       <= '0;
            mem_en_reg    <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            case (state_reg)
                IDLE: begin
                    if (launch) state_reg <= ISSUE;
                end
                ISSUE: begin
                    ack_reg   <= gnt_oh;
                    store_reg <= mem_we_reg;
                    state_reg <= ACK;
                end
                ACK: begin
                    if (!locked) ptr_reg <= gnt_inc;
                    state_reg <= launch ? ISSUE : IDLE;
                end
                default: state_reg <= IDLE;
            endcase
            if (launch) begin
                gnt_reg       <= win;
                mem_en_reg    <= 1'b1;
                mem_we_reg    <= issue_we;
                mem_addr_reg  <= issue_addr;
                mem_wdata_reg <= issue_wdata;
            end
        end
    end

    // Memory data arrives in the ACK cycle, so it is passed through, gated to 0 otherwise.
    assign bus.RData    = ((|ack_reg) && !store_reg) ? bus.MemRData : '0;
    assign bus.Ack      = ack_reg;
    assign bus.MemEn    = mem_en_reg;
    assign bus.MemWe    = mem_we_reg;
    assign bus.MemAddr  = mem_addr_reg;
    assign bus.MemWData = mem_wdata_reg;
    assign bus.Busy     = (state_reg != IDLE);
endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Bench for shared_mem_arbiter: transaction-level reference model plus directed scenarios.
// Lock scenario is compiled in when SHARED_MEM_LOCK_EN is defined.
module tb_shared_mem_arbiter;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    shared_mem_arbiter_if #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    shared_mem_arbiter #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .Clk   (clk),
        .Reset (rst_n),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory device: 16 words, read data valid the cycle after the strobe.
    logic [31:0] ram [16];
    bit ram_ready = 1'b0;
    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < 16; i++) ram[i] <= 32'h0;
            ram_ready <= 1'b1;
        end else if (bus.MemEn) begin
            if (bus.MemWe) ram[bus.MemAddr[5:2]] <= bus.MemWData;
            else           bus.MemRData <= ram[bus.MemAddr[5:2]];
        end
    end

    // Reference model: one transaction in flight, described by owner core and its age
    // (1 = memory cycle, 2 = acknowledge cycle); ref_mem holds committed stores.
    logic [31:0] ref_mem [16];
    int          m_core = -1;
    int          m_age  = 0;
    int          m_ptr  = 0;
    logic        m_we   = 1'b0;
    logic [31:0] m_addr = 32'h0;
    logic [31:0] m_wdata = 32'h0;
    bit          started = 1'b0;

    initial begin
        for (int i = 0; i < 16; i++) ref_mem[i] = 32'h0;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m_core  = -1;
                m_age   = 0;
                m_ptr   = 0;
                started = 1'b1;
            end else if (m_core >= 0 && m_age == 1) begin
                m_age = 2;
            end else begin
                logic [N-1:0] cand;
                bit           locked;
                cand   = bus.Req;
                locked = 1'b0;
                if (m_core >= 0) begin
                    if (m_we) ref_mem[m_addr[5:2]] = m_wdata;
`ifdef SHARED_MEM_LOCK_EN
                    locked = bus.Lock[m_core];
`endif
                    if (locked) cand = cand & (N'(1) << m_core);
                    else begin
                        m_ptr = (m_core + 1) % N;
                        cand[m_core] = 1'b0;
                    end
                end
                m_core = -1;
                for (int k = 0; k < N; k++)
                    if (m_core < 0 && cand[(m_ptr + k) % N]) m_core = (m_ptr + k) % N;
                if (m_core >= 0) begin
                    m_age   = 1;
                    m_we    = bus.We[m_core];
                    m_addr  = bus.Addr[m_core*AW +: AW];
                    m_wdata = bus.WData[m_core*DW +: DW];
                end
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    logic [N-1:0] last_ack = '0;
    initial begin
        forever begin
            @(negedge clk);
            last_ack = bus.Ack;
            if (started) begin
                logic [N-1:0] e_ack;
                logic         e_en;
                logic [31:0]  e_rd;
                e_ack = (m_core >= 0 && m_age == 2) ? (N'(1) << m_core) : '0;
                e_en  = (m_core >= 0 && m_age == 1);
                e_rd  = ((|e_ack) && !m_we) ? ref_mem[m_addr[5:2]] : 32'h0;
                chk("m_ack",   64'(bus.Ack),      64'(e_ack));
                chk("m_en",    64'(bus.MemEn),    64'(e_en));
                chk("m_we",    64'(bus.MemWe),    64'(e_en && m_we));
                chk("m_addr",  64'(bus.MemAddr),  64'(e_en ? m_addr : 32'h0));
                chk("m_wdata", 64'(bus.MemWData), 64'(e_en ? m_wdata : 32'h0));
                chk("m_rdata", 64'(bus.RData),    64'(e_rd));
                chk("m_busy",  64'(bus.Busy),     64'(m_core >= 0));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_req(input int c, input logic we, input logic [31:0] a, input logic [31:0] d);
        bus.Req[c] = 1'b1;
        bus.We[c]  = we;
        bus.Addr[c*AW +: AW]  = a;
        bus.WData[c*DW +: DW] = d;
    endtask

    task automatic rand_req(input int c);
        set_req(c, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)) * 32'd4, $urandom);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    int cnt [N];
    int order_n;
    int order_bad;

    initial begin
        bus.Req = '0;
        bus.We = '0;
        bus.Addr = '0;
        bus.WData = '0;
`ifdef SHARED_MEM_LOCK_EN
        bus.Lock = '0;
`endif
        // Reset held for 4 cycles, then idle with no requests
        rst_n = 1'b0;
        repeat (4) tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("rst_ack",  64'(bus.Ack),   64'(0));
        chk("rst_en",   64'(bus.MemEn), 64'(0));
        chk("rst_busy", 64'(bus.Busy),  64'(0));

        // Single store from core0, then core1 loads it back
        set_req(0, 1'b1, 32'h10, 32'hDEADBEEF);
        tick();
        chk("wr_en",    64'(bus.MemEn),    64'(1));
        chk("wr_we",    64'(bus.MemWe),    64'(1));
        chk("wr_addr",  64'(bus.MemAddr),  64'(32'h10));
        chk("wr_wdata", 64'(bus.MemWData), 64'(32'hDEADBEEF));
        tick();
        chk("wr_ack",   64'(bus.Ack),      64'(4'b0001));
        tick();
        bus.Req[0] = 1'b0;
        set_req(1, 1'b0, 32'h10, 32'h0);
        tick();
        tick();
        chk("rd_ack",   64'(bus.Ack),   64'(4'b0010));
        chk("rd_data",  64'(bus.RData), 64'(32'hDEADBEEF));
        tick();
        bus.Req[1] = 1'b0;

        // Contention between core0 and core1 from pointer 0, then a second tie
        do_reset();
        set_req(0, 1'b0, 32'h20, 32'h0);
        set_req(1, 1'b0, 32'h24, 32'h0);
        tick();
        tick();
        chk("cont_ack0", 64'(bus.Ack), 64'(4'b0001));
        tick();
        bus.Req[0] = 1'b0;
        tick();
        chk("cont_ack1", 64'(bus.Ack), 64'(4'b0010));
        tick();
        bus.Req[1] = 1'b0;
        tick();
        set_req(0, 1'b0, 32'h20, 32'h0);
        set_req(1, 1'b0, 32'h24, 32'h0);
        tick();
        tick();
        chk("tie_ack0", 64'(bus.Ack), 64'(4'b0001));
        tick();
        bus.Req[0] = 1'b0;
        tick();
        tick();
        bus.Req[1] = 1'b0;
        tick();

        // Fairness: all four cores request for 40 cycles
        do_reset();
        for (int i = 0; i < N; i++) begin
            set_req(i, 1'b0, 32'(i * 4), 32'h0);
            cnt[i] = 0;
        end
        order_n = 0;
        order_bad = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            for (int i = 0; i < N; i++) begin
                if (bus.Ack[i]) begin
                    if (i != order_n % N) order_bad++;
                    cnt[i]++;
                    order_n++;
                end
            end
        end
        bus.Req = '0;
        chk("fair_order_errs", 64'(order_bad), 64'(0));
        for (int i = 0; i < N; i++) chk($sformatf("fair_cnt%0d", i), 64'(cnt[i]), 64'(5));
        tick();
        tick();

        // Reset during the memory cycle of a core1 load
        do_reset();
        set_req(1, 1'b0, 32'h10, 32'h0);
        tick();
        chk("mid_en", 64'(bus.MemEn), 64'(1));
        rst_n = 1'b0;
        tick();
        chk("mid_ack",  64'(bus.Ack),   64'(0));
        chk("mid_busy", 64'(bus.Busy),  64'(0));
        chk("mid_en0",  64'(bus.MemEn), 64'(0));
        rst_n = 1'b1;
        tick();
        chk("mid_reissue_addr", 64'(bus.MemAddr), 64'(32'h10));
        tick();
        chk("mid_ack1",  64'(bus.Ack),   64'(4'b0010));
        chk("mid_rdata", 64'(bus.RData), 64'(32'hDEADBEEF));
        tick();
        bus.Req[1] = 1'b0;
        tick();

`ifdef SHARED_MEM_LOCK_EN
        // Core0 keeps the memory for three accesses while core1 waits
        do_reset();
        bus.Lock[0] = 1'b1;
        set_req(0, 1'b0, 32'h30, 32'h0);
        set_req(1, 1'b0, 32'h34, 32'h0);
        tick();
        tick();
        chk("lock_ack1", 64'(bus.Ack), 64'(4'b0001));
        tick();
        tick();
        chk("lock_ack2", 64'(bus.Ack), 64'(4'b0001));
        tick();
        bus.Lock[0] = 1'b0;
        tick();
        chk("lock_ack3", 64'(bus.Ack), 64'(4'b0001));
        tick();
        bus.Req[0] = 1'b0;
        tick();
        chk("lock_ack_c1", 64'(bus.Ack), 64'(4'b0010));
        tick();
        bus.Req[1] = 1'b0;
        tick();
`endif

        // Random traffic: requests held until acked, then dropped or renewed
        do_reset();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            tick();
            for (int i = 0; i < N; i++) begin
                if (bus.Req[i]) begin
                    if (last_ack[i]) begin
                        if ($urandom_range(0, 2) == 0) bus.Req[i] = 1'b0;
                        else rand_req(i);
                    end
                end else if ($urandom_range(0, 3) == 0) begin
                    rand_req(i);
                end
            end
        end
        for (int cyc = 0; cyc < 100; cyc++) begin
            tick();
            for (int i = 0; i < N; i++)
                if (bus.Req[i] && last_ack[i]) bus.Req[i] = 1'b0;
        end
        chk("drain_req", 64'(bus.Req), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
